mem_controller: RTL and testbench

- Single-port main-memory controller between the instruction cache / data cache and the backing word RAM.
- Arbitrates instruction fetch against data access; data access has priority.
- Serves scalar reads, scalar writes, read bursts and write bursts. Burst addresses are generated internally from the latched base address.
- Reports progress to both caches on one shared mem_status bus.

---
 rtl/mem_controller_if.sv | 49 ++++
 rtl/mem_controller.sv | 161 ++++++++++++++++
 tb/tb_mem_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_if.sv
// Cache-side and RAM-side signal bundle for mem_controller.
// Optional mem_addr_err exists only when MEM_CTRL_ADDR_CHECK_EN is defined.
interface mem_controller_if #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3
);
    logic [ADDR_WIDTH-1:0]       inst_addr;
    logic                        inst_req;
    logic [LEN-1:0]              inst_data;
    logic                        inst_valid;
    logic [1:0]                  mem_vis_signal;
    logic [ADDR_WIDTH-1:0]       mem_vis_addr;
    logic [LEN-1:0]              mem_writen_data;
    logic [ENTRY_INDEX_SIZE:0]   write_length;
    logic [LEN-1:0]              mem_data;
    logic                        mem_data_valid;
    logic [1:0]                  mem_status;
    logic [ADDR_WIDTH-3:0]       ram_addr;
    logic                        ram_re;
    logic                        ram_we;
    logic [LEN-1:0]              ram_wdata;
    logic [LEN-1:0]              ram_rdata;
`ifdef MEM_CTRL_ADDR_CHECK_EN
    logic                        mem_addr_err;
`endif

    modport slave (
        input  inst_addr, inst_req, mem_vis_signal, mem_vis_addr, mem_writen_data,
               write_length, ram_rdata,
        output
`ifdef MEM_CTRL_ADDR_CHECK_EN
               mem_addr_err,
`endif
               inst_data, inst_valid, mem_data, mem_data_valid, mem_status,
               ram_addr, ram_re, ram_we, ram_wdata
    );

    modport master (
        output inst_addr, inst_req, mem_vis_signal, mem_vis_addr, mem_writen_data,
               write_length, ram_rdata,
        input
`ifdef MEM_CTRL_ADDR_CHECK_EN
               mem_addr_err,
`endif
               inst_data, inst_valid, mem_data, mem_data_valid, mem_status,
               ram_addr, ram_re, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_controller.sv
// Single-port RAM controller arbitrating I-cache fetch vs D-cache access (data wins); scalar and burst.
// Latency: 2 cycles per beat, single read valid 3 cycles after IDLE acceptance; requests are level-held (no backpressure).
// Optional MEM_CTRL_ADDR_CHECK_EN: adds mem_addr_err and rejects misaligned / top-crossing requests.
module mem_controller #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int VECTOR_SIZE      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_controller_if.slave  bus
);
    localparam int WA = ADDR_WIDTH - 2;
    localparam int CW = ENTRY_INDEX_SIZE + 1;
    localparam logic [CW-1:0] VEC = CW'(VECTOR_SIZE);

    localparam logic [1:0] MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2, MEM_READ_BURST = 2'd3;
    localparam logic [1:0] ST_REST = 2'd0, ST_INST = 2'd1, ST_DATA = 2'd2, ST_FIN = 2'd3;

    typedef enum logic [2:0] {IDLE, I_ISSUE, I_RESP, D_ISSUE, D_RESP, D_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [WA-1:0]   base_q, base_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   tgt_q, tgt_d;
    logic [LEN-1:0]  inst_data_q, inst_data_d;
    logic            inst_valid_q, inst_valid_d;
    logic [LEN-1:0]  mem_data_q, mem_data_d;
    logic            mem_data_valid_q, mem_data_valid_d;
    logic [1:0]      status_q, status_d;
    logic [CW-1:0]   req_len;
    logic            issue_live;

    assign req_len = (bus.mem_vis_signal == MEM_READ_BURST) ? VEC :
                     (bus.mem_vis_signal == MEM_READ || bus.write_length == '0) ? CW'(1) :
                     bus.write_length;

`ifdef MEM_CTRL_ADDR_CHECK_EN
    logic err_q, err_d;
    logic data_err, inst_err;
    assign data_err = (bus.mem_vis_addr[1:0] != 2'b00) ||
                      (({1'b0, bus.mem_vis_addr[ADDR_WIDTH-1:2]} + (WA+1)'(req_len)) > {1'b1, {WA{1'b0}}});
    assign inst_err = (bus.inst_addr[1:0] != 2'b00);
    assign bus.mem_addr_err = err_q;
`else
    logic unused_lo;
    assign unused_lo = ^{bus.mem_vis_addr[1:0], bus.inst_addr[1:0]};
`endif

    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        base_d           = base_q;
        cnt_d            = cnt_q;
        tgt_d            = tgt_q;
        inst_data_d      = inst_data_q;
        inst_valid_d     = 1'b0;
        mem_data_d       = mem_data_q;
        mem_data_valid_d = 1'b0;
`ifdef MEM_CTRL_ADDR_CHECK_EN
        err_d            = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mem_vis_signal != MEM_NOP) begin
                    cmd_d   = bus.mem_vis_signal;
                    base_d  = bus.mem_vis_addr[ADDR_WIDTH-1:2];
                    cnt_d   = '0;
                    tgt_d   = req_len;
                    state_d = D_ISSUE;
`ifdef MEM_CTRL_ADDR_CHECK_EN
                    err_d = data_err;
                    if (data_err) state_d = D_DONE;
`endif
                // inst_valid_q blocks re-accepting the fetch the cache is still holding this cycle
                end else if (bus.inst_req && !inst_valid_q) begin
                    base_d  = bus.inst_addr[ADDR_WIDTH-1:2];
                    cnt_d   = '0;
                    state_d = I_ISSUE;
`ifdef MEM_CTRL_ADDR_CHECK_EN
                    err_d = inst_err;
                    if (inst_err) begin
                        state_d      = IDLE;
                        inst_valid_d = 1'b1;
                        inst_data_d  = '0;
                    end
`endif
                end
            end
            I_ISSUE: state_d = I_RESP;
            I_RESP: begin
                inst_data_d  = bus.ram_rdata;
                inst_valid_d = 1'b1;
                state_d      = IDLE;
            end
            D_ISSUE: state_d = (bus.mem_vis_signal == MEM_NOP) ? D_DONE : D_RESP;
            D_RESP: begin
                mem_data_valid_d = 1'b1;
                if (cmd_q != MEM_WRITE) mem_data_d = bus.ram_rdata;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_d == tgt_q || cmd_q == MEM_READ) ? D_DONE : D_ISSUE;
            end
            D_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:              status_d = ST_REST;
            I_ISSUE, I_RESP:   status_d = ST_INST;
            D_ISSUE, D_RESP:   status_d = ST_DATA;
            default:           status_d = ST_FIN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cmd_q            <= MEM_NOP;
            base_q           <= '0;
            cnt_q            <= '0;
            tgt_q            <= '0;
            inst_data_q      <= '0;
            inst_valid_q     <= 1'b0;
            mem_data_q       <= '0;
            mem_data_valid_q <= 1'b0;
            status_q         <= ST_REST;
`ifdef MEM_CTRL_ADDR_CHECK_EN
            err_q            <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            base_q           <= base_d;
            cnt_q            <= cnt_d;
            tgt_q            <= tgt_d;
            inst_data_q      <= inst_data_d;
            inst_valid_q     <= inst_valid_d;
            mem_data_q       <= mem_data_d;
            mem_data_valid_q <= mem_data_valid_d;
            status_q         <= status_d;
`ifdef MEM_CTRL_ADDR_CHECK_EN
            err_q            <= err_d;
`endif
        end
    end

    // RAM strobes decode from the state register so a NOP abort can suppress the access in the same cycle
    assign issue_live     = (state_q == D_ISSUE) && (bus.mem_vis_signal != MEM_NOP);
    assign bus.ram_re     = (state_q == I_ISSUE) || (issue_live && cmd_q != MEM_WRITE);
    assign bus.ram_we     = issue_live && (cmd_q == MEM_WRITE);
    assign bus.ram_wdata  = bus.ram_we ? bus.mem_writen_data : '0;
    assign bus.ram_addr   = base_q + WA'(cnt_q);

    assign bus.inst_data      = inst_data_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.mem_data       = mem_data_q;
    assign bus.mem_data_valid = mem_data_valid_q;
    assign bus.mem_status     = status_q;
endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a one-cycle-latency word RAM model.
module tb_mem_controller;
    localparam int AW = 17, LEN = 32, EIS = 3, VS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_controller_if #(.ADDR_WIDTH(AW), .LEN(LEN), .ENTRY_INDEX_SIZE(EIS)) bus();

    mem_controller #(.ADDR_WIDTH(AW), .LEN(LEN), .ENTRY_INDEX_SIZE(EIS), .VECTOR_SIZE(VS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0]   ram [0:(1<<(AW-2))-1];
    logic [AW-3:0] re_log[$];
    logic [AW-3:0] we_addr[$];
    logic [31:0]   we_dat[$];
    int            both_hi = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ram[16] <= 32'hDEADBEEF;
            ram[17] <= 32'hCAFEF00D;
            for (int i = 0; i < 8; i++) ram[64+i] <= 32'h1000 + i;
        end
        if (bus.ram_re) begin
            bus.ram_rdata <= ram[bus.ram_addr];
            re_log.push_back(bus.ram_addr);
        end
        if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
            we_addr.push_back(bus.ram_addr);
            we_dat.push_back(bus.ram_wdata);
        end
        if (bus.ram_re && bus.ram_we) both_hi++;
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int n, beats, last, gap_bad;

    initial begin
        bus.inst_addr       = '0;
        bus.inst_req        = 1'b0;
        bus.mem_vis_signal  = 2'd0;
        bus.mem_vis_addr    = '0;
        bus.mem_writen_data = '0;
        bus.write_length    = '0;

        // reset state
        repeat (3) step();
        chk("rst_status", bus.mem_status, 0);
        chk("rst_re", bus.ram_re, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_dvalid", bus.mem_data_valid, 0);
        chk("rst_ivalid", bus.inst_valid, 0);
        rst_n = 1'b1;
        repeat (20) step();
        chk("idle_status", bus.mem_status, 0);
        chk("idle_strobes", re_log.size() + we_addr.size(), 0);

        // single read
        bus.mem_vis_signal = 2'd1; bus.mem_vis_addr = 17'h40;
        n = 0;
        do begin step(); n++; end while (!bus.mem_data_valid && n < 20);
        chk("rd_latency", n, 3);
        chk("rd_data", bus.mem_data, 32'hDEADBEEF);
        chk("rd_fin_status", bus.mem_status, 3);
        chk("rd_count", re_log.size(), 1);
        chk("rd_addr", re_log[0], 16);
        bus.mem_vis_signal = 2'd0;
        step();
        chk("rd_after_status", bus.mem_status, 0);
        chk("rd_after_dvalid", bus.mem_data_valid, 0);

        // read burst
        re_log.delete();
        bus.mem_vis_signal = 2'd3; bus.mem_vis_addr = 17'h100;
        beats = 0; n = 0; last = 0; gap_bad = 0;
        while (beats < 8 && n < 60) begin
            step(); n++;
            if (bus.mem_data_valid) begin
                if (beats > 0 && n - last != 2) gap_bad++;
                chk("bst_data", bus.mem_data, 32'h1000 + beats);
                last = n; beats++;
            end
        end
        chk("bst_beats", beats, 8);
        chk("bst_gap", gap_bad, 0);
        chk("bst_fin_status", bus.mem_status, 3);
        chk("bst_count", re_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("bst_addr", re_log[i], 64 + i);
        bus.mem_vis_signal = 2'd0;
        step();

        // write burst of 4, data advanced on each beat completion
        we_addr.delete(); we_dat.delete();
        bus.mem_vis_signal = 2'd2; bus.mem_vis_addr = 17'h20; bus.write_length = 4'd4;
        bus.mem_writen_data = 32'd1;
        beats = 0; n = 0;
        while (bus.mem_status != 2'd3 && n < 40) begin
            step(); n++;
            if (bus.mem_data_valid) begin beats++; bus.mem_writen_data = beats + 1; end
        end
        chk("wr_beats", beats, 4);
        chk("wr_count", we_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", we_addr[i], 8 + i);
            chk("wr_data", we_dat[i], i + 1);
        end
        chk("wr_no_overlap", both_hi, 0);
        bus.mem_vis_signal = 2'd0;
        step();

        // readback of the written words
        bus.mem_vis_signal = 2'd3; bus.mem_vis_addr = 17'h20;
        beats = 0; n = 0;
        while (bus.mem_status != 2'd3 && n < 60) begin
            step(); n++;
            if (bus.mem_data_valid) begin
                if (beats < 4) chk("rb_data", bus.mem_data, beats + 1);
                beats++;
            end
        end
        chk("rb_beats", beats, 8);
        bus.mem_vis_signal = 2'd0;
        step();

        // write_length 0 behaves as a single beat
        we_addr.delete(); we_dat.delete();
        bus.mem_vis_signal = 2'd2; bus.mem_vis_addr = 17'h200; bus.write_length = 4'd0;
        bus.mem_writen_data = 32'h55;
        n = 0;
        while (bus.mem_status != 2'd3 && n < 20) begin step(); n++; end
        chk("wl0_count", we_addr.size(), 1);
        chk("wl0_addr", we_addr[0], 128);
        chk("wl0_data", we_dat[0], 32'h55);
        bus.mem_vis_signal = 2'd0;
        step();

        // NOP in D_ISSUE aborts without a RAM access
        we_addr.delete(); we_dat.delete();
        bus.mem_vis_signal = 2'd2; bus.mem_vis_addr = 17'h300; bus.write_length = 4'd4;
        step();
        chk("abt_working", bus.mem_status, 2);
        bus.mem_vis_signal = 2'd0;
        step();
        chk("abt_fin", bus.mem_status, 3);
        chk("abt_dvalid", bus.mem_data_valid, 0);
        chk("abt_no_write", we_addr.size(), 0);
        step();
        chk("abt_idle", bus.mem_status, 0);

        // simultaneous fetch and data read: data first
        re_log.delete();
        bus.inst_req = 1'b1; bus.inst_addr = 17'h40;
        bus.mem_vis_signal = 2'd1; bus.mem_vis_addr = 17'h44;
        step();
        chk("arb_data_first", bus.mem_status, 2);
        n = 0;
        while (bus.mem_status != 2'd3 && n < 20) begin step(); n++; end
        chk("arb_ddata", bus.mem_data, 32'hCAFEF00D);
        bus.mem_vis_signal = 2'd0;
        n = 0;
        do begin step(); n++; end while (!bus.inst_valid && n < 20);
        chk("arb_inst_lat", n, 4);
        chk("arb_idata", bus.inst_data, 32'hDEADBEEF);
        bus.inst_req = 1'b0;
        step();
        chk("arb_inst_once", bus.inst_valid, 0);
        chk("arb_re_count", re_log.size(), 2);
        chk("arb_inst_addr", re_log[1], 16);

        // reset in the middle of a burst
        bus.mem_vis_signal = 2'd3; bus.mem_vis_addr = 17'h100;
        beats = 0; n = 0;
        while (beats < 3 && n < 40) begin
            step(); n++;
            if (bus.mem_data_valid) beats++;
        end
        chk("mrst_pre_re", bus.ram_re, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_re", bus.ram_re, 0);
        chk("mrst_status", bus.mem_status, 0);
        chk("mrst_dvalid", bus.mem_data_valid, 0);
        chk("mrst_data", bus.mem_data, 0);
        re_log.delete();
        bus.mem_vis_signal = 2'd0;
        repeat (3) step();
        chk("mrst_no_strobe", re_log.size(), 0);
        rst_n = 1'b1;
        step();
        bus.mem_vis_signal = 2'd1; bus.mem_vis_addr = 17'h40;
        n = 0;
        do begin step(); n++; end while (!bus.mem_data_valid && n < 20);
        chk("post_rst_lat", n, 3);
        chk("post_rst_data", bus.mem_data, 32'hDEADBEEF);
        bus.mem_vis_signal = 2'd0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
